// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and data access.
// Alternates grants on conflict, drops flushed fetches, and bounds each access with a watchdog.
module unified_mem_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  input  logic [3:0]    dm_be,
  output logic [31:0]   dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic          timeout_err,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester holds x_req and its command stable until x_valid is
  // seen high; x_valid lasts exactly one cycle and the requester may present a
  // new request on the following cycle. On the memory side, mem_* is held
  // stable while mem_req=1 until a cycle with mem_ready=1 completes it.

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_DM = 2'd1,
    SERVE_IF = 2'd2
  } state_t;

  state_t        state;
  logic          last_grant_dm;
  logic          kill;
  logic [CW-1:0] wd_cnt;

  logic          if_cand;
  logic          grant_dm;
  logic          grant_if;
  logic          serving;
  logic          wd_expire;
  logic          done;
  logic [31:0]   rdata;

  // A flush in IDLE only hides the fetch for this cycle; the request stays pending.
  assign if_cand  = if_req & ~if_flush;
  assign grant_dm = dm_req & (~if_cand | ~last_grant_dm);
  assign grant_if = if_cand & ~grant_dm;

  assign serving   = (state != IDLE);
  assign wd_expire = WD_EN && serving && (wd_cnt == WD_LAST) && !mem_ready;
  assign done      = serving & (mem_ready | wd_expire);

  // A timed-out access completes with zero data rather than whatever the bus floats.
  assign rdata    = wd_expire ? 32'h0 : mem_rdata;
  assign if_rdata = rdata;
  assign dm_rdata = rdata;

  assign if_valid = (state == SERVE_IF) & done & ~kill & ~if_flush;
  assign dm_valid = (state == SERVE_DM) & done;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant_dm <= 1'b0;
      kill          <= 1'b0;
      wd_cnt        <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= 4'b0000;
      timeout_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wd_cnt <= '0;
          kill   <= 1'b0;
          if (grant_dm) begin
            state     <= SERVE_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_we ? dm_be : 4'b0000;
          end else if (grant_if) begin
            state     <= SERVE_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
          end
        end
        SERVE_DM, SERVE_IF: begin
          if (done) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            last_grant_dm <= (state == SERVE_DM);
            kill          <= 1'b0;
            if (wd_expire) begin
              timeout_err <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
            // The memory access cannot be recalled, so a flush only marks its result stale.
            if ((state == SERVE_IF) && if_flush) begin
              kill <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: vector table, hand-written corner sequences, and a random
// two-requester run checked against a transaction-level memory model.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [31:0]   if_rdata;
  logic          if_valid;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [3:0]    dm_be;
  logic [31:0]   dm_rdata;
  logic          dm_valid;
  logic          dm_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  unified_mem_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  task automatic apply_reset();
    rst      = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] phys_mem [logic [29:0]];
  logic [31:0] ref_mem  [logic [29:0]];
  logic        mem_hang;
  logic        rand_lat;
  int          mem_lat;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[17:2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] a);
    if (phys_mem.exists(a[31:2])) return phys_mem[a[31:2]];
    return data_of({a[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return data_of({a[31:2], 2'b00});
  endfunction

  // Responder: a command is seen as new on the first negedge mem_req is high after being low.
  initial begin : responder
    logic prev_req;
    int   resp_cnt;
    int   resp_lat;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    prev_req  = 1'b0;
    resp_cnt  = 0;
    resp_lat  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ready = 1'b0;
        prev_req  = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          resp_cnt = 0;
          resp_lat = rand_lat ? int'($urandom_range(0, 5)) : mem_lat;
        end
        if (mem_req && !mem_hang && resp_cnt == resp_lat) begin
          mem_ready = 1'b1;
          mem_rdata = phys_read(mem_addr);
          if (mem_we) phys_mem[mem_addr[31:2]] = merge(phys_read(mem_addr), mem_wdata, mem_be);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
        end
        if (mem_req) resp_cnt++;
        prev_req = mem_req;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_before;
    int          lat;
    logic        ifr;
    logic [31:0] ifa;
    logic        fl;
    logic        dmr;
    logic [31:0] dma;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_ifv;
    logic        e_dmv;
    logic        e_ifs;
    logic        e_dms;
  } vec_t;

  vec_t vecs[40];
  int   n_vec;

  task automatic add_vec(input logic rb, input int lat, input logic ifr, input logic [31:0] ifa,
                         input logic fl, input logic dmr, input logic [31:0] dma, input logic em,
                         input logic [31:0] ea, input logic eiv, input logic edv, input logic eis,
                         input logic eds);
    vecs[n_vec] = '{rb, lat, ifr, ifa, fl, dmr, dma, em, ea, eiv, edv, eis, eds};
    n_vec++;
  endtask

  // ---------------- scoreboard state for random run ----------------
  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];

  task automatic run_dm_load(input logic [31:0] addr, output int serve, output logic got,
                             output logic [31:0] rd);
    serve   = 0;
    got     = 1'b0;
    rd      = 32'h0;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = addr;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk); #2;
      if (mem_req) serve++;
      if (dm_valid) begin
        got = 1'b1;
        rd  = dm_rdata;
      end
      @(posedge clk); #1;
    end
    dm_req = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: bench did not finish, got running, expected done");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int          serve;
    logic        got;
    logic [31:0] rd;
    int          nfetch;
    int          dv_cnt;
    logic        if_busy, dm_busy, if_got, dm_got, abort;
    int          if_wait, dm_wait, n_if_done, n_dm_done;
    logic [31:0] ra, wd, ev;
    logic [3:0]  rbe;

    n_cmp    = 0;
    n_fail   = 0;
    n_vec    = 0;
    mem_hang = 1'b0;
    rand_lat = 1'b0;
    mem_lat  = 0;

    // Reset values, sampled while reset is held.
    rst = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    @(negedge clk); #2;
    check("rst.mem_req", mem_req, 0);
    check("rst.mem_cmd", {mem_we, mem_be, mem_addr[27:0]}, 0);
    check("rst.mem_wdata", mem_wdata, 0);
    check("rst.timeout_err", timeout_err, 0);
    check("rst.state", dbg_state, 0);
    check("rst.valids", {if_valid, dm_valid}, 0);
    apply_reset();

    // Single load, latency 3: stall for 4 cycles, valid on the 4th serve cycle.
    add_vec(1, 3, 0, 0, 0, 1, 32'h40, 0, 0,      0, 0, 0, 1);
    add_vec(0, 3, 0, 0, 0, 1, 32'h40, 1, 32'h40, 0, 0, 0, 1);
    add_vec(0, 3, 0, 0, 0, 1, 32'h40, 1, 32'h40, 0, 0, 0, 1);
    add_vec(0, 3, 0, 0, 0, 1, 32'h40, 1, 32'h40, 0, 0, 0, 1);
    add_vec(0, 3, 0, 0, 0, 1, 32'h40, 1, 32'h40, 0, 1, 0, 0);
    add_vec(0, 3, 0, 0, 0, 0, 32'h40, 0, 0,      0, 0, 0, 0);
    // Conflicts after reset: DM, then IF, then DM.
    add_vec(1, 1, 1, 32'h200, 0, 1, 32'h80, 0, 0,       0, 0, 1, 1);
    add_vec(0, 1, 1, 32'h200, 0, 1, 32'h80, 1, 32'h80,  0, 0, 1, 1);
    add_vec(0, 1, 1, 32'h200, 0, 1, 32'h80, 1, 32'h80,  0, 1, 1, 0);
    add_vec(0, 1, 1, 32'h200, 0, 1, 32'h84, 0, 0,       0, 0, 1, 1);
    add_vec(0, 1, 1, 32'h200, 0, 1, 32'h84, 1, 32'h200, 0, 0, 1, 1);
    add_vec(0, 1, 1, 32'h200, 0, 1, 32'h84, 1, 32'h200, 1, 0, 0, 1);
    add_vec(0, 1, 1, 32'h204, 0, 1, 32'h84, 0, 0,       0, 0, 1, 1);
    add_vec(0, 1, 1, 32'h204, 0, 1, 32'h84, 1, 32'h84,  0, 0, 1, 1);
    add_vec(0, 1, 1, 32'h204, 0, 1, 32'h84, 1, 32'h84,  0, 1, 1, 0);
    add_vec(0, 1, 0, 0,       0, 0, 0,      0, 0,       0, 0, 0, 0);
    // Flush during a fetch, then flush in IDLE blocking one grant.
    add_vec(1, 2, 1, 32'h300, 0, 0, 0, 0, 0,       0, 0, 1, 0);
    add_vec(0, 2, 1, 32'h300, 1, 0, 0, 1, 32'h300, 0, 0, 1, 0);
    add_vec(0, 2, 1, 32'h100, 0, 0, 0, 1, 32'h300, 0, 0, 1, 0);
    add_vec(0, 2, 1, 32'h100, 0, 0, 0, 1, 32'h300, 0, 0, 1, 0);
    add_vec(0, 2, 1, 32'h100, 1, 0, 0, 0, 0,       0, 0, 1, 0);
    add_vec(0, 2, 1, 32'h100, 0, 0, 0, 0, 0,       0, 0, 1, 0);
    add_vec(0, 2, 1, 32'h100, 0, 0, 0, 1, 32'h100, 0, 0, 1, 0);
    add_vec(0, 2, 1, 32'h100, 0, 0, 0, 1, 32'h100, 0, 0, 1, 0);
    add_vec(0, 2, 1, 32'h100, 0, 0, 0, 1, 32'h100, 1, 0, 0, 0);
    add_vec(0, 2, 0, 0,       0, 0, 0, 0, 0,       0, 0, 0, 0);

    for (int i = 0; i < n_vec; i++) begin
      if (vecs[i].rst_before) apply_reset();
      mem_lat  = vecs[i].lat;
      if_req   = vecs[i].ifr;
      if_addr  = vecs[i].ifa;
      if_flush = vecs[i].fl;
      dm_req   = vecs[i].dmr;
      dm_we    = 1'b0;
      dm_addr  = vecs[i].dma;
      @(negedge clk); #2;
      check($sformatf("vec%0d.mem_req", i), mem_req, vecs[i].e_mreq);
      check($sformatf("vec%0d.if_valid", i), if_valid, vecs[i].e_ifv);
      check($sformatf("vec%0d.dm_valid", i), dm_valid, vecs[i].e_dmv);
      check($sformatf("vec%0d.stalls", i), {if_stall, dm_stall}, {vecs[i].e_ifs, vecs[i].e_dms});
      if (vecs[i].e_mreq) begin
        check($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].e_maddr);
        check($sformatf("vec%0d.mem_we_be", i), {mem_we, mem_be}, 0);
      end
      if (vecs[i].e_ifv) check($sformatf("vec%0d.if_rdata", i), if_rdata, phys_read(vecs[i].ifa));
      if (vecs[i].e_dmv) check($sformatf("vec%0d.dm_rdata", i), dm_rdata, phys_read(vecs[i].dma));
      @(posedge clk); #1;
    end

    // Watchdog: ready on the last allowed cycle is normal; no ready at all times out.
    apply_reset();
    mem_lat = 7;
    run_dm_load(32'h500, serve, got, rd);
    check("wd_edge.got", got, 1);
    check("wd_edge.serve", serve, 8);
    check("wd_edge.rdata", rd, data_of(32'h500));
    @(negedge clk); #2;
    check("wd_edge.no_err", timeout_err, 0);
    @(posedge clk); #1;
    mem_hang = 1'b1;
    run_dm_load(32'h504, serve, got, rd);
    mem_hang = 1'b0;
    check("wd_hang.got", got, 1);
    check("wd_hang.serve", serve, TO);
    check("wd_hang.rdata", rd, 0);
    @(negedge clk); #2;
    check("wd_hang.err", timeout_err, 1);
    check("wd_hang.idle", {mem_req, dbg_state}, 0);
    @(posedge clk); #1;
    mem_lat = 0;
    run_dm_load(32'h508, serve, got, rd);
    check("wd_after.serve", serve, 1);
    check("wd_after.rdata", rd, data_of(32'h508));
    @(negedge clk); #2;
    check("wd_after.sticky", timeout_err, 1);
    @(posedge clk); #1;

    // Zero-wait memory with continuous fetches: one fetch every two cycles.
    apply_reset();
    mem_lat = 0;
    if_req  = 1'b1;
    if_addr = 32'h1000;
    nfetch  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #2;
      got = if_valid;
      if (mem_req) check($sformatf("zw%0d.we_be", k), {mem_we, mem_be}, 0);
      if (if_valid) begin
        nfetch++;
        check($sformatf("zw%0d.rdata", k), if_rdata, data_of(if_addr));
      end
      @(posedge clk); #1;
      if (got) if_addr = if_addr + 32'd4;
    end
    if_req = 1'b0;
    check("zw.fetch_count", nfetch, 10);

    // Reset in the middle of a data access.
    apply_reset();
    mem_lat = 5;
    dm_req  = 1'b1;
    dm_addr = 32'h600;
    @(negedge clk); #2;
    @(posedge clk); #1;
    @(negedge clk); #2;
    check("mid_rst.serving", mem_req, 1);
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst.mem_req_drop", mem_req, 0);
    dm_req = 1'b0;
    dv_cnt = 0;
    repeat (3) begin
      @(negedge clk); #2;
      dv_cnt += int'(dm_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); #2;
      dv_cnt += int'(dm_valid);
    end
    check("mid_rst.no_valid", dv_cnt, 0);
    check("mid_rst.idle", {mem_req, dbg_state}, 0);
    check("mid_rst.err_clear", timeout_err, 0);
    @(posedge clk); #1;

    // Random two-requester traffic. Fetches read a region nobody writes; data
    // accesses use a separate region whose contents ref_mem tracks at issue time.
    apply_reset();
    rand_lat  = 1'b1;
    if_busy   = 0; dm_busy = 0; if_got = 0; dm_got = 0; abort = 0;
    if_wait   = 0; dm_wait = 0; n_if_done = 0; n_dm_done = 0;
    for (int cyc = 0; cyc < 600 && !abort; cyc++) begin
      if (if_got) begin if_busy = 0; if_got = 0; if_req = 0; end
      if (dm_got) begin dm_busy = 0; dm_got = 0; dm_req = 0; end
      if (!if_busy && $urandom_range(0, 2) == 0) begin
        if_busy = 1; if_wait = 0;
        if_addr = 32'h1000 + ($urandom_range(0, 63) << 2);
        if_req  = 1'b1;
        if_exp_q.push_back(data_of(if_addr));
      end
      if (!dm_busy && $urandom_range(0, 2) == 0) begin
        dm_busy = 1; dm_wait = 0;
        ra  = 32'h2000 + ($urandom_range(0, 15) << 2);
        wd  = $urandom;
        rbe = 4'($urandom_range(1, 15));
        dm_addr = ra; dm_wdata = wd; dm_be = rbe;
        dm_we   = 1'($urandom_range(0, 1));
        dm_req  = 1'b1;
        if (dm_we) ref_mem[ra[31:2]] = merge(ref_read(ra), wd, rbe);
        else dm_exp_q.push_back(ref_read(ra));
      end
      @(negedge clk); #2;
      check($sformatf("rnd%0d.stalls", cyc), {if_stall, dm_stall},
            {if_req && !if_valid, dm_req && !dm_valid});
      if (if_valid) begin
        if (!if_busy || if_exp_q.size() == 0) begin
          check($sformatf("rnd%0d.if_spurious", cyc), 1, 0);
        end else begin
          ev = if_exp_q.pop_front();
          check($sformatf("rnd%0d.if_rdata", cyc), if_rdata, ev);
          check($sformatf("rnd%0d.if_cmd", cyc), {mem_we, mem_be}, 0);
          check($sformatf("rnd%0d.if_addr", cyc), mem_addr, if_addr);
          if_got = 1; n_if_done++;
        end
      end
      if (dm_valid) begin
        if (!dm_busy) begin
          check($sformatf("rnd%0d.dm_spurious", cyc), 1, 0);
        end else begin
          check($sformatf("rnd%0d.dm_addr", cyc), mem_addr, dm_addr);
          if (dm_we) begin
            check($sformatf("rnd%0d.st_cmd", cyc), {mem_we, mem_be}, {1'b1, dm_be});
            check($sformatf("rnd%0d.st_wdata", cyc), mem_wdata, dm_wdata);
          end else begin
            check($sformatf("rnd%0d.ld_cmd", cyc), {mem_we, mem_be}, 0);
            if (dm_exp_q.size() == 0) check($sformatf("rnd%0d.ld_spurious", cyc), 1, 0);
            else check($sformatf("rnd%0d.ld_rdata", cyc), dm_rdata, dm_exp_q.pop_front());
          end
          dm_got = 1; n_dm_done++;
        end
      end
      if (if_busy && !if_got) if_wait++;
      if (dm_busy && !dm_got) dm_wait++;
      if (if_wait > 40 || dm_wait > 40) begin
        check("rnd.progress_bound", {if_wait > 40, dm_wait > 40}, 0);
        abort = 1;
      end
      @(posedge clk); #1;
    end
    rand_lat = 1'b0;
    check("rnd.if_done_min", n_if_done >= 20, 1);
    check("rnd.dm_done_min", n_dm_done >= 20, 1);
    check("rnd.no_timeout", timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
